// File: rtl/ahb_mem_slave.sv
// ahb_mem_slave: AHB-Lite word-addressed RAM responder with programmable wait states and two-cycle ERROR
// Ports:
//   HCLK, HRESETn            bus clock (rising edge), asynchronous active-low reset
//   HADDR, HWRITE, HSIZE     address-phase word address, direction, size (only 3'b010 legal)
//   HBURST, HTRANS           burst type (informational), transfer type IDLE/BUSY/NON_SEQ/SEQ
//   HWDATA                   data-phase write data
//   HRDATA, HREADY, HRESP    registered read data, ready (also the bus HREADY), OKAY/ERROR
// Optional feature: define RO_PROTECT_EN to make words at or above RO_BASE read-only.
module ahb_mem_slave #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_DEPTH     = 256,
    parameter int WAIT_STATES   = 0,
    parameter int RO_BASE       = 192
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [ADDRESS_WIDTH-1:0] HADDR,
    input  logic                     HWRITE,
    input  logic [2:0]               HSIZE,
    input  logic [2:0]               HBURST,
    input  logic [1:0]               HTRANS,
    input  logic [DATA_WIDTH-1:0]    HWDATA,
    output logic [DATA_WIDTH-1:0]    HRDATA,
    output logic                     HREADY,
    output logic                     HRESP
);
    localparam int AW = $clog2(MEM_DEPTH);
    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} state_t;
    state_t                  state;
    logic [3:0]              cnt;
    logic [AW-1:0]           addr_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
    logic                    sample, range_err, ro_hit, ro_err, err, wr_commit, rd_load;
    logic [AW-1:0]           idx, rd_idx;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    unused_in;
    // single-slave bus: our own registered HREADY is the bus HREADY seen by the address phase
    assign sample    = HREADY && HTRANS[1];
    assign idx       = HADDR[AW-1:0];
    assign range_err = HADDR >= ADDRESS_WIDTH'(MEM_DEPTH);
    assign ro_hit    = HWRITE && HADDR >= ADDRESS_WIDTH'(RO_BASE);
`ifdef RO_PROTECT_EN
    assign ro_err    = ro_hit;
    assign unused_in = ^{HBURST, HTRANS[0]};
`else
    assign ro_err    = 1'b0;
    assign unused_in = ^{HBURST, HTRANS[0], ro_hit};
`endif
    assign err       = HSIZE != 3'b010 || range_err || ro_err;
    assign wr_commit = state == ST_DATA && wr_q;
    // HRDATA is loaded on the edge entering ST_DATA, either leaving ST_WAIT or straight from sampling
    assign rd_load   = (state == ST_WAIT && cnt == 4'd0 && !wr_q) ||
                       (sample && !err && !HWRITE && WAIT_STATES == 0);
    assign rd_idx    = state == ST_WAIT ? addr_q : idx;
    // a write committing on this edge to the word being read forwards its data
    assign rd_word   = wr_commit && addr_q == rd_idx ? HWDATA : mem[rd_idx];
    always_ff @(posedge HCLK) begin
        if (wr_commit) mem[addr_q] <= HWDATA;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state  <= ST_IDLE;
            HREADY <= 1'b1;
            HRESP  <= 1'b0;
            HRDATA <= '0;
            cnt    <= '0;
            addr_q <= '0;
            wr_q   <= 1'b0;
        end else begin
            if (rd_load) HRDATA <= rd_word;
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_DATA;
                        HREADY <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state  <= ST_ERR2;
                    HREADY <= 1'b1;
                    HRESP  <= 1'b1;
                end
                default: begin
                    if (sample) begin
                        addr_q <= idx;
                        wr_q   <= HWRITE;
                        if (err) begin
                            state  <= ST_ERR1;
                            HREADY <= 1'b0;
                            HRESP  <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state  <= ST_WAIT;
                            HREADY <= 1'b0;
                            HRESP  <= 1'b0;
                            cnt    <= 4'(WAIT_STATES - 1);
                        end else begin
                            state  <= ST_DATA;
                            HREADY <= 1'b1;
                            HRESP  <= 1'b0;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        HREADY <= 1'b1;
                        HRESP  <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
